// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types and defaults for the convolution frame sequencer.
package conv_frame_ctrl_pkg;
  localparam int LEN    = 3;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {IDLE, PRE, RUN, POST, DRAIN} ctrl_state_t;
  typedef enum logic {FULL = 1'b0, VALID = 1'b1} conv_mode_t;
endpackage

// File: rtl/conv_frame_ctrl_win_filter.sv
// Window accounting: drops warm-up windows, forwards the rest, tags the last.
module conv_win_filter #(
  parameter int LEN   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tot_i,
  input  logic             win_valid_i,
  output logic             win_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             last_xfer_o
);
  localparam logic [CNT_W-1:0] WARM = CNT_W'(LEN-1);

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             warm;

  always_comb begin
    warm        = win_cnt_q < WARM;
    win_ready_o = en_i && (warm || out_ready_i);
    out_valid_o = en_i && !warm && win_valid_i;
    out_last_o  = out_valid_o && ((win_cnt_q - WARM) == (tot_i - CNT_W'(1)));
    last_xfer_o = out_last_o && out_ready_i;
    win_cnt_d   = win_cnt_q;
    if (!en_i)                           win_cnt_d = '0;
    else if (win_valid_i && win_ready_o) win_cnt_d = win_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) win_cnt_q <= '0;
    else      win_cnt_q <= win_cnt_d;
  end
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: meters samples into the window datapath, zero-pads in FULL
// mode and hands window accounting to conv_win_filter.
module conv_frame_ctrl #(
  parameter int LEN   = conv_frame_ctrl_pkg::LEN,
  parameter int CNT_W = conv_frame_ctrl_pkg::CNT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 mode,
  input  logic [CNT_W-1:0]                     cfg_len,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  input  logic [conv_frame_ctrl_pkg::DATA_W-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [conv_frame_ctrl_pkg::DATA_W-1:0] sh_data,
  output logic                                 sh_valid,
  input  logic                                 sh_ready,
  input  logic                                 win_valid,
  output logic                                 win_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last
);
  import conv_frame_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LM1   = CNT_W'(LEN-1);
  localparam logic [CNT_W-1:0] LM2   = CNT_W'(LEN-2);

  ctrl_state_t      state_q;
  conv_mode_t       mode_q;
  logic [CNT_W-1:0] n_q, tot_q, cnt_q;
  logic             done_q, err_q;
  logic             inj, last_xfer;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;
  assign inj  = sh_valid && sh_ready;

  // RUN is a pure combinational pass-through; PRE/POST inject zeros.
  always_comb begin
    sh_valid = 1'b0;
    sh_data  = '0;
    in_ready = 1'b0;
    case (state_q)
      PRE, POST: sh_valid = 1'b1;
      RUN: begin
        sh_valid = in_valid;
        sh_data  = in_data;
        in_ready = sh_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= FULL;
      n_q     <= '0;
      tot_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (cfg_len == '0 || (conv_mode_t'(mode) == VALID && cfg_len < LEN_C)) begin
              err_q <= 1'b1;
            end else begin
              n_q     <= cfg_len;
              mode_q  <= conv_mode_t'(mode);
              tot_q   <= (conv_mode_t'(mode) == VALID) ? cfg_len - LM1 : cfg_len + LM1;
              cnt_q   <= '0;
              state_q <= (conv_mode_t'(mode) == VALID) ? RUN : PRE;
            end
          end
          PRE: if (inj) begin
            cnt_q <= (cnt_q == LM2) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == LM2) state_q <= RUN;
          end
          RUN: if (inj) begin
            cnt_q <= (cnt_q == n_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == n_q - CNT_W'(1)) state_q <= (mode_q == FULL) ? POST : DRAIN;
          end
          POST: if (inj) begin
            cnt_q <= (cnt_q == LM2) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == LM2) state_q <= DRAIN;
          end
          DRAIN: if (last_xfer) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Gating with abort keeps a same-cycle last window from being forwarded.
  conv_win_filter #(.LEN(LEN), .CNT_W(CNT_W)) u_filter (
    .clk         (clk),
    .rst         (rst),
    .en_i        (busy && !abort),
    .tot_i       (tot_q),
    .win_valid_i (win_valid),
    .win_ready_o (win_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_last_o  (out_last),
    .last_xfer_o (last_xfer)
  );
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl with a 3-tap window datapath model.
module tb_conv_frame_ctrl;
  logic        clk, rst, start, mode, abort;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic [7:0]  in_data, sh_data;
  logic        in_valid, in_ready, sh_valid, sh_ready;
  logic        win_valid, win_ready, out_valid, out_ready, out_last;

  conv_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cfg_len(cfg_len), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sh_data(sh_data), .sh_valid(sh_valid), .sh_ready(sh_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [7:0]  exp_sh[$];
  logic [24:0] exp_out[$];   // {last, oldest, middle, newest}
  bit          ignore = 1'b0;
  bit          sh_en = 1'b1, or_tog = 1'b0, last_pend = 1'b0;

  // Upstream source (append-only), window datapath model, downstream ready.
  logic [7:0]  src [64];
  logic [6:0]  src_idx, src_n;
  logic [23:0] wbuf;
  logic        win_pend;
  int          ninj;

  assign in_valid  = src_idx < src_n;
  assign in_data   = src[src_idx[5:0]];
  assign sh_ready  = sh_en && !win_pend;
  assign win_valid = win_pend;

  initial begin src_idx = '0; ninj = 0; wbuf = '0; out_ready = 1'b1; end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_pend  <= 1'b0;
      out_ready <= 1'b1;
    end else begin
      if (sh_valid && sh_ready) begin
        wbuf     <= {wbuf[15:0], sh_data};
        win_pend <= 1'b1;
        ninj     <= ninj + 1;
      end else if (win_valid && win_ready) begin
        win_pend <= 1'b0;
      end
      if (in_valid && in_ready) src_idx <= src_idx + 7'd1;
      out_ready <= or_tog ? ~out_ready : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. what the next rising edge transfers.
  always @(negedge clk) begin
    if (!rst) begin
      last_pend = 1'b0;
    end else begin
      if (done || last_pend) chk("done_pulse", {31'd0, done}, {31'd0, last_pend});
      last_pend = out_valid && out_ready && out_last;
      if (sh_valid && sh_ready && !ignore) begin
        if (exp_sh.size() == 0) chk("sh_extra", {24'd0, sh_data}, 32'hffff_ffff);
        else chk("sh_data", {24'd0, sh_data}, {24'd0, exp_sh.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (ignore) begin
          if (out_last) chk("abort_last", {31'd0, out_last}, 32'd0);
        end else if (exp_out.size() == 0) begin
          chk("out_extra", {7'd0, out_last, wbuf}, 32'hffff_ffff);
        end else begin
          chk("out_win", {7'd0, out_last, wbuf}, {7'd0, exp_out.pop_front()});
        end
      end
    end
  end

  task automatic load(input logic [7:0] v);
    src[src_n[5:0]] = v;
    src_n = src_n + 7'd1;
  endtask

  task automatic do_start(input logic m, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; mode = m; cfg_len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int k;
    k = 0;
    @(posedge clk); #1;
    while ((busy || exp_sh.size() != 0 || exp_out.size() != 0) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, {29'd0, busy, exp_sh.size() != 0, exp_out.size() != 0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic exp_full4();
    exp_sh = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
    exp_out = '{25'h0000001, 25'h0000102, 25'h0010203, 25'h0020304, 25'h0030400, 25'h1040000};
    for (int i = 1; i <= 4; i++) load(8'(i));
  endtask

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; mode = 1'b0; cfg_len = '0; abort = 1'b0; src_n = '0;
    @(posedge clk); #1;
    chk("reset_outs", {24'd0, in_ready, sh_valid, win_ready, out_valid, out_last, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // FULL, N=4
    exp_full4();
    do_start(1'b0, 16'd4);
    wait_frame("full4_end");

    // VALID, N=4
    exp_sh = '{8'd1, 8'd2, 8'd3, 8'd4};
    exp_out = '{25'h0010203, 25'h1020304};
    for (int i = 1; i <= 4; i++) load(8'(i));
    do_start(1'b1, 16'd4);
    wait_frame("valid4_end");

    // Rejected starts
    do_start(1'b1, 16'd2);
    chk("err_valid2", {29'd0, err, busy, in_ready}, 32'd4);
    @(posedge clk); #1;
    chk("err_clear", {30'd0, err, busy}, 32'd0);
    do_start(1'b0, 16'd0);
    chk("err_full0", {29'd0, err, busy, in_ready}, 32'd4);
    @(posedge clk); #1;
    chk("err_clear2", {30'd0, err, busy}, 32'd0);

    // Backpressure, FULL N=5
    or_tog = 1'b1;
    exp_sh = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0};
    exp_out = '{25'h0000001, 25'h0000102, 25'h0010203, 25'h0020304,
                25'h0030405, 25'h0040500, 25'h1050000};
    for (int i = 1; i <= 5; i++) load(8'(i));
    do_start(1'b0, 16'd5);
    k = 0;
    while (exp_sh.size() > 5 && k < 200) begin @(posedge clk); #1; k++; end
    sh_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 sh_en = 1'b1;
    wait_frame("bp_full5_end");
    or_tog = 1'b0;
    @(posedge clk); #1;

    // Abort in RUN after two samples, then a clean FULL N=4 frame
    ignore = 1'b1;
    load(8'd1); load(8'd2);
    do_start(1'b0, 16'd4);
    k = 0;
    while (src_idx != src_n && k < 200) begin @(posedge clk); #1; k++; end
    sh_en = 1'b0;
    k = 0;
    while (win_pend && k < 200) begin @(posedge clk); #1; k++; end
    chk("abort_in_run", {30'd0, busy, in_valid}, 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {30'd0, busy, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 sh_en = 1'b1; ignore = 1'b0;
    exp_full4();
    do_start(1'b0, 16'd4);
    wait_frame("post_abort_end");

    // Async reset mid-POST
    ignore = 1'b1;
    for (int i = 1; i <= 4; i++) load(8'(i));
    k = ninj;
    do_start(1'b0, 16'd4);
    while (ninj - k < 7 && ninj - k >= 0 && vectors < 100000 && $time < 64'd900000) begin
      @(posedge clk); #1;
    end
    chk("in_post", {30'd0, busy, sh_valid}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("reset_mid", {24'd0, in_ready, sh_valid, win_ready, out_valid, out_last, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset", {29'd0, busy, sh_valid, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
